// File: rtl/conv_pkg.sv
// Shared conv1 definitions: default image/kernel geometry, stream word width,
// beat-count arithmetic and the loader FSM state type.
package conv_pkg;

    localparam int IMG_BITS = 784;
    localparam int KER_BITS = 2250;
    localparam int WW       = 8;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam int IMG_BEATS = ceil_div(IMG_BITS, WW);
    localparam int KER_BEATS = ceil_div(KER_BITS, WW);
    localparam int BEAT_CNT_W = $clog2(KER_BEATS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_IMG = 2'd1,
        LOAD_KER = 2'd2,
        DONE     = 2'd3
    } load_state_e;

endpackage

// File: rtl/conv1_loader.sv
// Streams a binary image followed by 90 binary kernels into the wide conv1
// input registers, MSB-first, one WW-bit word per accepted beat.
module conv1_loader #(
    parameter int IMG_BITS = conv_pkg::IMG_BITS,
    parameter int KER_BITS = conv_pkg::KER_BITS,
    parameter int WW       = conv_pkg::WW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [WW-1:0]       in_data,
    output logic                in_ready,
    output logic [0:IMG_BITS-1] image,
    output logic [0:KER_BITS-1] kernels,
    output logic                busy,
    output logic                load_done
);
    import conv_pkg::*;

    localparam int N_IMG_BEATS = ceil_div(IMG_BITS, WW);
    localparam int N_KER_BEATS = ceil_div(KER_BITS, WW);
    localparam int CNT_W       = $clog2(N_KER_BEATS);
    localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(N_IMG_BEATS - 1);
    localparam logic [CNT_W-1:0] KER_LAST = CNT_W'(N_KER_BEATS - 1);

    load_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [0:IMG_BITS-1]   image_q, image_d;
    logic [0:KER_BITS-1]   kernels_q, kernels_d;
    logic                  busy_q, busy_d;
    logic                  load_done_q, load_done_d;
    logic                  img_we, ker_we;

    // in_ready is a pure state decode so in_valid never reaches it combinationally.
    assign in_ready = (state_q == LOAD_IMG) || (state_q == LOAD_KER);
    assign img_we   = (state_q == LOAD_IMG) && in_valid;
    assign ker_we   = (state_q == LOAD_KER) && in_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD_IMG;
                    cnt_d   = '0;
                end
            end
            LOAD_IMG: begin
                if (in_valid) begin
                    if (cnt_q == IMG_LAST) begin
                        state_d = LOAD_KER;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_KER: begin
                if (in_valid) begin
                    if (cnt_q == KER_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d      = (state_d == LOAD_IMG) || (state_d == LOAD_KER);
        load_done_d = (state_d == DONE);
    end

    // One slice per beat; the final slice is trimmed so padding bits are dropped.
    for (genvar b = 0; b < N_IMG_BEATS; b++) begin : g_img
        localparam int LO  = b * WW;
        localparam int LEN = (IMG_BITS - LO < WW) ? (IMG_BITS - LO) : WW;
        assign image_d[LO +: LEN] = (img_we && cnt_q == CNT_W'(b)) ?
                                    in_data[WW-1 -: LEN] : image_q[LO +: LEN];
    end

    for (genvar b = 0; b < N_KER_BEATS; b++) begin : g_ker
        localparam int LO  = b * WW;
        localparam int LEN = (KER_BITS - LO < WW) ? (KER_BITS - LO) : WW;
        assign kernels_d[LO +: LEN] = (ker_we && cnt_q == CNT_W'(b)) ?
                                      in_data[WW-1 -: LEN] : kernels_q[LO +: LEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            image_q     <= '0;
            kernels_q   <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            image_q     <= image_d;
            kernels_q   <= kernels_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
        end
    end

    assign image     = image_q;
    assign kernels   = kernels_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;

endmodule
